// File: rtl/ecc_mod_div.sv
// Sequential modular divider: o_result = i_num / i_den mod i_p by binary extended Euclid, one step per clock.
// Define ECC_MOD_DIV_TIMEOUT_EN to bound the CALC phase and flag non-terminating inputs through o_error.
module ecc_mod_div #(
  parameter int MAX_BITS = 192,
  parameter int CNT_BITS = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [MAX_BITS-1:0] i_p,
  input  logic [MAX_BITS-1:0] i_num,
  input  logic [MAX_BITS-1:0] i_den,
  output logic [MAX_BITS-1:0] o_result,
  output logic                o_finished,
  output logic                o_busy,
  output logic                o_error
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  localparam logic [CNT_BITS-1:0] STEP_LIMIT = CNT_BITS'(4 * MAX_BITS + 2);

  state_t              r_state, w_state;
  logic [MAX_BITS-1:0] r_u, w_u;
  logic [MAX_BITS-1:0] r_v, w_v;
  logic [MAX_BITS-1:0] r_x1, w_x1;
  logic [MAX_BITS-1:0] r_x2, w_x2;
  logic [MAX_BITS-1:0] r_pm, w_pm;
  logic [CNT_BITS-1:0] r_step, w_step;
  logic [MAX_BITS-1:0] r_result, w_result;
  logic                r_finished, w_finished;
  logic                r_busy, w_busy;
  logic                r_error, w_error;

  // x/2 mod pm; the sum is formed one bit wider so the carry survives the shift.
  function automatic logic [MAX_BITS-1:0] half_mod(input logic [MAX_BITS-1:0] x,
                                                   input logic [MAX_BITS-1:0] pm);
    logic [MAX_BITS:0] s;
    s = x[0] ? ({1'b0, x} + {1'b0, pm}) : {1'b0, x};
    return s[MAX_BITS:1];
  endfunction

  // (a - b) mod pm for a, b already in [0, pm).
  function automatic logic [MAX_BITS-1:0] sub_mod(input logic [MAX_BITS-1:0] a,
                                                  input logic [MAX_BITS-1:0] b,
                                                  input logic [MAX_BITS-1:0] pm);
    logic [MAX_BITS:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[MAX_BITS] ? (d[MAX_BITS-1:0] + pm) : d[MAX_BITS-1:0];
  endfunction

  always_comb begin
    w_state    = r_state;
    w_u        = r_u;
    w_v        = r_v;
    w_x1       = r_x1;
    w_x2       = r_x2;
    w_pm       = r_pm;
    w_step     = r_step;
    w_result   = r_result;
    w_finished = 1'b0;
    w_busy     = r_busy;
    w_error    = r_error;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_u    = i_den;
          w_v    = i_p;
          w_x1   = i_num;
          w_x2   = '0;
          w_pm   = i_p;
          w_step = '0;
          w_busy = 1'b1;
          if (i_den == '0) begin
            w_error  = 1'b1;
            w_result = '1;
            w_state  = S_DONE;
          end else begin
            w_error = 1'b0;
            w_state = S_CALC;
          end
        end
      end
      S_CALC: begin
        w_step = r_step + CNT_BITS'(1);
        if (r_u == MAX_BITS'(1)) begin
          w_result = r_x1;
          w_state  = S_DONE;
        end else if (r_v == MAX_BITS'(1)) begin
          w_result = r_x2;
          w_state  = S_DONE;
`ifdef ECC_MOD_DIV_TIMEOUT_EN
        end else if (r_step == STEP_LIMIT) begin
          w_result = '1;
          w_error  = 1'b1;
          w_state  = S_DONE;
`endif
        end else if (!r_u[0]) begin
          w_u  = r_u >> 1;
          w_x1 = half_mod(r_x1, r_pm);
        end else if (!r_v[0]) begin
          w_v  = r_v >> 1;
          w_x2 = half_mod(r_x2, r_pm);
        end else if (r_u >= r_v) begin
          w_u  = r_u - r_v;
          w_x1 = sub_mod(r_x1, r_x2, r_pm);
        end else begin
          w_v  = r_v - r_u;
          w_x2 = sub_mod(r_x2, r_x1, r_pm);
        end
      end
      S_DONE: begin
        // Completion is registered, so the pulse shows in the following IDLE cycle.
        w_finished = 1'b1;
        w_busy     = 1'b0;
        w_state    = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_u        <= '0;
      r_v        <= '0;
      r_x1       <= '0;
      r_x2       <= '0;
      r_pm       <= '0;
      r_step     <= '0;
      r_result   <= '1;
      r_finished <= 1'b0;
      r_busy     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_u        <= w_u;
      r_v        <= w_v;
      r_x1       <= w_x1;
      r_x2       <= w_x2;
      r_pm       <= w_pm;
      r_step     <= w_step;
      r_result   <= w_result;
      r_finished <= w_finished;
      r_busy     <= w_busy;
      r_error    <= w_error;
    end
  end

  assign o_result   = r_result;
  assign o_finished = r_finished;
  assign o_busy     = r_busy;
  assign o_error    = r_error;

endmodule

// File: tb/tb_ecc_mod_div.sv
// Scoreboard bench for ecc_mod_div: expected quotients come from a Fermat-inverse model (den^(p-2)).
module tb_ecc_mod_div;
  localparam int MB = 192;
  localparam logic [MB-1:0] P192 = 192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFFFF_FFFFFFFF;
  localparam logic [MB-1:0] ONES = '1;
  localparam logic [MB-1:0] P23  = MB'(23);

  typedef struct {
    logic [MB-1:0] res;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [MB-1:0] p = '0, num = '0, den = '0;
  logic [MB-1:0] o_result;
  logic          o_finished, o_busy, o_error;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   fin_count = 0;
  exp_t sb[$];

  ecc_mod_div #(.MAX_BITS(MB), .CNT_BITS(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_p(p), .i_num(num), .i_den(den),
    .o_result(o_result), .o_finished(o_finished), .o_busy(o_busy), .o_error(o_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (o_finished) fin_count <= fin_count + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [MB-1:0] mulmod(input logic [MB-1:0] a, input logic [MB-1:0] b,
                                           input logic [MB-1:0] m);
    logic [2*MB-1:0] t;
    t = ({{MB{1'b0}}, a} * {{MB{1'b0}}, b}) % {{MB{1'b0}}, m};
    return t[MB-1:0];
  endfunction

  function automatic logic [MB-1:0] modpow(input logic [MB-1:0] b, input logic [MB-1:0] e,
                                           input logic [MB-1:0] m);
    logic [MB-1:0] r;
    r = MB'(1);
    for (int i = MB - 1; i >= 0; i--) begin
      r = mulmod(r, r, m);
      if (e[i]) r = mulmod(r, b, m);
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [MB-1:0] got, input logic [MB-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic launch(input logic [MB-1:0] pp, input logic [MB-1:0] nn,
                        input logic [MB-1:0] dd, input bit push);
    exp_t e;
    @(negedge clk);
    p = pp; num = nn; den = dd; start = 1'b1;
    start_cyc = cyc;
    if (push) begin
      if (dd == '0) begin
        e.res = ONES; e.err = 1'b1;
      end else begin
        e.res = mulmod(nn, modpow(dd, pp - MB'(2), pp), pp); e.err = 1'b0;
      end
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, output int lat);
    bit   busy_ok;
    bit   seen;
    exp_t e;
    busy_ok = 1'b1;
    seen = 1'b0;
    lat = -1;
    for (int n = 0; n < 4 * MB + 20; n++) begin
      if (o_finished) begin
        seen = 1'b1;
        break;
      end
      if (!o_busy) busy_ok = 1'b0;
      @(negedge clk);
    end
    if (!seen) begin
      check({tag, "_finished_timeout"}, MB'(o_finished), MB'(1));
      return;
    end
    lat = cyc - start_cyc;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, MB'(0), MB'(1));
    end else begin
      e = sb.pop_front();
      check({tag, "_result"}, o_result, e.res);
      check({tag, "_error"}, MB'(o_error), MB'(e.err));
    end
    check({tag, "_busy_during"}, MB'(busy_ok), MB'(1));
    check({tag, "_busy_at_finish"}, MB'(o_busy), MB'(0));
    if (exp_lat >= 0) check({tag, "_latency"}, MB'(lat), MB'(exp_lat));
    @(negedge clk);
    check({tag, "_finish_one_cycle"}, MB'(o_finished), MB'(0));
  endtask

  initial begin
    int            lat;
    int            fin_before;
    logic [MB-1:0] d, nr;

    repeat (3) @(negedge clk);
    check("rst_result", o_result, ONES);
    check("rst_finished", MB'(o_finished), MB'(0));
    check("rst_busy", MB'(o_busy), MB'(0));
    check("rst_error", MB'(o_error), MB'(0));
    rst = 1'b0;

    launch(P23, MB'(1), MB'(2), 1'b1);
    wait_done("p23_1_2", 4, lat);
    check("p23_1_2_const", o_result, MB'(12));

    launch(P23, MB'(5), MB'(3), 1'b1);
    wait_done("p23_5_3", -1, lat);
    check("p23_5_3_const", o_result, MB'(17));

    launch(P23, MB'(7), MB'(1), 1'b1);
    wait_done("p23_7_1", 3, lat);
    check("p23_7_1_const", o_result, MB'(7));

    launch(P23, MB'(9), MB'(0), 1'b1);
    wait_done("p23_den0", 2, lat);

    // A start while busy must not disturb the running 5/3.
    launch(P23, MB'(5), MB'(3), 1'b1);
    @(negedge clk);
    num = MB'(1); den = MB'(2); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("ignored_start", -1, lat);
    check("ignored_start_const", o_result, MB'(17));
    check("ignored_start_sb_drained", MB'(sb.size()), MB'(0));
    launch(P23, MB'(1), MB'(2), 1'b1);
    wait_done("reassert", 4, lat);

    d = '0;
    for (int i = 0; i < 6; i++) d = {d[MB-33:0], 32'($urandom())};
    d = d % P192;
    if (d == '0) d = MB'(5);

    // Reset mid-CALC: operation lost, no completion pulse.
    launch(P192, MB'(1), d, 1'b0);
    repeat (10) @(negedge clk);
    fin_before = fin_count;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_result", o_result, ONES);
    check("midrst_busy", MB'(o_busy), MB'(0));
    check("midrst_finished", MB'(o_finished), MB'(0));
    check("midrst_error", MB'(o_error), MB'(0));
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_finish", MB'(fin_count), MB'(fin_before));

    launch(P192, MB'(1), d, 1'b1);
    wait_done("p192_inv", -1, lat);
    check("p192_inv_times_den", mulmod(o_result, d, P192), MB'(1));
    check("p192_inv_latency_bound", MB'(lat <= 4 * MB + 3), MB'(1));

    for (int k = 0; k < 2; k++) begin
      nr = '0;
      d = '0;
      for (int i = 0; i < 6; i++) begin
        nr = {nr[MB-33:0], 32'($urandom())};
        d  = {d[MB-33:0], 32'($urandom())};
      end
      nr = nr % P192;
      d = d % P192;
      if (d == '0) d = MB'(3);
      launch(P192, nr, d, 1'b1);
      wait_done("p192_rand", -1, lat);
      check("p192_rand_latency_bound", MB'(lat <= 4 * MB + 3), MB'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
